// File: rtl/mult8_nib_seq.sv
// mult8_nib_seq: sequential 8x8 unsigned multiplier built around one shared
// 4x4 array multiplier. Each operation takes four nibble-product steps, which
// are shifted and accumulated into a 16-bit register. Completion is signalled
// by a one-cycle done pulse.
//
// Handshake: start is a request that is accepted on a rising edge only while
// the controller is in IDLE or DONE. a/b are captured on that same edge.
// start seen in MUL is ignored. done is high for exactly one cycle, and p is
// valid from that cycle until the next completion.

// 4x4 unsigned combinational array multiplier (AND-gated partial products).
module mult (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [7:0] p
);
    logic [7:0] w_pp0;
    logic [7:0] w_pp1;
    logic [7:0] w_pp2;
    logic [7:0] w_pp3;

    assign w_pp0 = {4'b0000, x & {4{y[0]}}};
    assign w_pp1 = {3'b000,  x & {4{y[1]}}, 1'b0};
    assign w_pp2 = {2'b00,   x & {4{y[2]}}, 2'b00};
    assign w_pp3 = {1'b0,    x & {4{y[3]}}, 3'b000};
    assign p     = w_pp0 + w_pp1 + w_pp2 + w_pp3;
endmodule

module mult8_nib_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        busy,
    output logic        done,
    output logic [15:0] p,
    output logic [1:0]  o_dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [1:0]  r_k;
    logic [7:0]  r_ra;
    logic [7:0]  r_rb;
    logic [15:0] r_acc;
    logic [15:0] r_p;

    logic [3:0]  w_x;
    logic [3:0]  w_y;
    logic [3:0]  w_sh;
    logic [7:0]  w_up;
    logic [15:0] w_term;
    logic [15:0] w_sum;
    logic        w_accept;

    mult u_mult (
        .x (w_x),
        .y (w_y),
        .p (w_up)
    );

    // Select the nibble pair and shift for the current step; idle the unit outside MUL.
    always_comb begin
        w_x  = 4'd0;
        w_y  = 4'd0;
        w_sh = 4'd0;
        if (r_state == S_MUL) begin
            case (r_k)
                2'd0: begin w_x = r_ra[3:0]; w_y = r_rb[3:0]; w_sh = 4'd0; end
                2'd1: begin w_x = r_ra[7:4]; w_y = r_rb[3:0]; w_sh = 4'd4; end
                2'd2: begin w_x = r_ra[3:0]; w_y = r_rb[7:4]; w_sh = 4'd4; end
                default: begin w_x = r_ra[7:4]; w_y = r_rb[7:4]; w_sh = 4'd8; end
            endcase
        end
    end

    // Max result 0xFE01 fits in 16 bits, so truncating intermediate sums is exact.
    assign w_term   = {8'h00, w_up} << w_sh;
    assign w_sum    = r_acc + w_term;
    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // Next-state decode for the IDLE -> MUL(x4) -> DONE sequence.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (start) w_next_state = S_MUL;
            S_MUL:  if (r_k == 2'd3) w_next_state = S_DONE;
            S_DONE: w_next_state = start ? S_MUL : S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // Operand capture, step counter, accumulator and result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ra  <= 8'h00;
            r_rb  <= 8'h00;
            r_acc <= 16'h0000;
            r_k   <= 2'd0;
            r_p   <= 16'h0000;
        end else if (w_accept) begin
            r_ra  <= a;
            r_rb  <= b;
            r_acc <= 16'h0000;
            r_k   <= 2'd0;
        end else if (r_state == S_MUL) begin
            r_acc <= w_sum;
            r_k   <= r_k + 2'd1;
            if (r_k == 2'd3) r_p <= w_sum;
        end
    end

    // Outputs decode from state/registers only; no path from start, a or b.
    assign busy        = (r_state == S_MUL);
    assign done        = (r_state == S_DONE);
    assign p           = r_p;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_mult8_nib_seq.sv
// Directed bench for mult8_nib_seq: vector table, hand-written multi-cycle
// corner cases, a strided operand sweep and a busy/done width monitor.
module tb_mult8_nib_seq;
    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] p;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef struct {
        logic [7:0]  va;
        logic [7:0]  vb;
        logic [15:0] vp;
    } vec_t;

    vec_t vecs[10];

    mult8_nib_seq dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .p           (p),
        .o_dbg_state (dbg_state)
    );

    // Clock: 10 ns period, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: busy runs are exactly 4 cycles, done is never wider than 1 cycle.
    int  busy_run = 0;
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            busy_run  = 0;
            prev_done = 1'b0;
        end else begin
            if (busy) begin
                busy_run++;
            end else if (busy_run != 0) begin
                chk("busy_run_len", busy_run, 4);
                busy_run = 0;
            end
            if (done) chk("done_width", {31'd0, prev_done}, 0);
            prev_done = done;
        end
    end

    // Issue one operation from a negedge, wait for done, check latency, result and hold.
    task automatic do_op(input string name, input logic [7:0] ta, input logic [7:0] tb,
                         input logic [15:0] texp);
        int lat;
        bit got;
        @(negedge clk);
        start = 1'b1;
        a     = ta;
        b     = tb;
        @(negedge clk);
        start = 1'b0;
        a     = ~ta;
        b     = ~tb;
        got = 1'b0;
        lat = 0;
        for (int i = 1; i <= 10 && !got; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                lat = i;
            end
        end
        chk({name, "_done_seen"}, {31'd0, got}, 1);
        chk({name, "_latency"}, lat, 4);
        chk({name, "_p"}, {16'd0, p}, {16'd0, texp});
        @(negedge clk);
        chk({name, "_done_low"}, {31'd0, done}, 0);
        chk({name, "_p_hold"}, {16'd0, p}, {16'd0, texp});
    endtask

    initial begin
        int n_done;
        bit got;

        vecs[0] = '{8'h0F, 8'h0F, 16'h00E1};
        vecs[1] = '{8'hFF, 8'hFF, 16'hFE01};
        vecs[2] = '{8'h12, 8'h34, 16'h03A8};
        vecs[3] = '{8'h00, 8'hA5, 16'h0000};
        vecs[4] = '{8'h07, 8'h09, 16'h003F};
        vecs[5] = '{8'h80, 8'h02, 16'h0100};
        vecs[6] = '{8'hAB, 8'hCD, 16'h88EF};
        vecs[7] = '{8'h01, 8'hFF, 16'h00FF};
        vecs[8] = '{8'hF0, 8'h0F, 16'h0E10};
        vecs[9] = '{8'h0F, 8'hF0, 16'h0E10};

        rst   = 1'b1;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        #2;
        chk("rst_busy",  {31'd0, busy}, 0);
        chk("rst_done",  {31'd0, done}, 0);
        chk("rst_p",     {16'd0, p}, 0);
        chk("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;

        // First op: check busy stays high for the four step cycles.
        @(negedge clk);
        start = 1'b1; a = 8'h0F; b = 8'h0F;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("first_busy", {31'd0, busy}, 1);
            chk("first_state", {30'd0, dbg_state}, {30'd0, ST_MUL});
            @(negedge clk);
        end
        chk("first_done", {31'd0, done}, 1);
        chk("first_p", {16'd0, p}, 32'h00E1);
        repeat (3) @(negedge clk);
        chk("first_idle_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        chk("first_idle_hold", {16'd0, p}, 32'h00E1);

        // Table of directed vectors.
        for (int i = 0; i < 10; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vp);
        end

        // start pulsed during MUL k=1 is ignored.
        @(negedge clk);
        start = 1'b1; a = 8'h02; b = 8'h03;
        @(negedge clk);               // k=0 cycle
        start = 1'b0;
        @(negedge clk);               // k=1 cycle
        start = 1'b1; a = 8'hFF; b = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) begin
                n_done++;
                chk("ign_p", {16'd0, p}, 32'h0006);
            end
            @(negedge clk);
        end
        chk("ign_done_count", n_done, 1);
        chk("ign_busy_after", {31'd0, busy}, 0);
        chk("ign_state_after", {30'd0, dbg_state}, {30'd0, ST_IDLE});

        // Back-to-back with start held high.
        @(negedge clk);
        start = 1'b1; a = 8'h10; b = 8'h10;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        chk("b2b_first_done", {31'd0, got}, 1);
        chk("b2b_first_p", {16'd0, p}, 32'h0100);
        a = 8'h03; b = 8'h05;
        @(negedge clk);
        chk("b2b_reenter_busy", {31'd0, busy}, 1);
        chk("b2b_reenter_done", {31'd0, done}, 0);
        start = 1'b0;
        n_done = 0;
        for (int i = 1; i <= 6 && n_done == 0; i++) begin
            @(negedge clk);
            if (done) n_done = i + 1;   // cycles since first done
        end
        chk("b2b_spacing", n_done, 5);
        chk("b2b_second_p", {16'd0, p}, 32'h000F);

        // Asynchronous reset during step k=2.
        repeat (2) @(negedge clk);
        start = 1'b1; a = 8'hFF; b = 8'hFF;
        @(negedge clk);               // k=0
        start = 1'b0;
        @(negedge clk);               // k=1
        @(negedge clk);               // k=2
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_done", {31'd0, done}, 0);
        chk("mid_rst_p", {16'd0, p}, 0);
        chk("mid_rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        @(negedge clk);
        #2 rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("mid_rst_no_done", n_done, 0);
        chk("mid_rst_p_stays", {16'd0, p}, 0);
        do_op("after_rst", 8'h07, 8'h09, 16'h003F);

        // Strided operand sweep against a*b.
        for (int ia = 0; ia < 256; ia += 5) begin
            for (int ib = 0; ib < 256; ib += 7) begin
                logic [15:0] e;
                e = 16'(ia * ib);
                do_op("sweep", 8'(ia), 8'(ib), e);
            end
        end
        do_op("sweep_max", 8'hFF, 8'hFE, 16'hFD02);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #5ms;
        n_err++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
